// File: rtl/risc16_bus_pkg.sv
// Shared types for the risc16 memory-port arbiter slice.
// Pure declarations: no logic, no latency.
// Backpressure: not applicable.
package risc16_bus_pkg;

    // Which requester owns the read data returning on the memory bus this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_H    = 2'd3
    } owner_t;

    // Core run / halt sequencing.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } arb_state_t;

    // Byte-lane write-enable value that marks an access as a read.
    localparam logic [1:0] WE_NONE = 2'b00;

    // True when a write-enable field describes a read access.
    function automatic logic is_read(input logic [1:0] we);
        return we == WE_NONE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, host and memory-side signals around the port arbiter.
// Wires only: no latency.
// Backpressure: grants are the only flow control; a lost request simply retries.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // instruction-fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    // core data port
    logic              d_req;
    logic [1:0]        d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    // host loader / debug port
    logic              h_halt_req;
    logic              h_halted;
    logic              h_req;
    logic [1:0]        h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              h_gnt;
    logic              h_rvalid;
    logic [DATA_W-1:0] h_rdata;
    // memory side
    logic [ADDR_W-1:0] m_addr;
    logic              m_oe;
    logic [1:0]        m_we;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    // core pipeline freeze
    logic              core_stall;

    // Arbiter view.
    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  h_halt_req,
        output h_halted,
        input  h_req, h_we, h_addr, h_wdata,
        output h_gnt, h_rvalid, h_rdata,
        output m_addr, m_oe, m_we, m_wdata,
        input  m_rdata,
        output core_stall
    );

    // Requester / memory-model view.
    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output h_halt_req,
        input  h_halted,
        output h_req, h_we, h_addr, h_wdata,
        input  h_gnt, h_rvalid, h_rdata,
        input  m_addr, m_oe, m_we, m_wdata,
        output m_rdata,
        input  core_stall
    );

endinterface

// File: rtl/arb_fair_sel.sv
// Fetch/data priority select with a bounded data streak so fetch cannot starve.
// Latency: selects are combinational; streak counter updates on the clock edge.
// Backpressure: the losing request is not selected and must be held by its owner.
module arb_fair_sel #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic enable_i,
    output logic sel_i_o,
    output logic sel_d_o
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

    logic [3:0] dstreak_q;
    logic [3:0] dstreak_d;
    logic       at_limit;

    assign at_limit = (dstreak_q == STREAK_MAX);

    // Data normally wins; a waiting fetch wins once data has had its full streak.
    assign sel_d_o = enable_i & d_req_i & ~(i_req_i & at_limit);
    assign sel_i_o = enable_i & i_req_i & ~sel_d_o;

    // Count data grants that overtook a waiting fetch; forget on fetch grant or no fetch.
    always_comb begin
        dstreak_d = dstreak_q;
        if (!i_req_i || sel_i_o) begin
            dstreak_d = 4'd0;
        end else if (sel_d_o && !at_limit) begin
            dstreak_d = dstreak_q + 4'd1;
        end
    end

    // Streak register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dstreak_q <= 4'd0;
        end else begin
            dstreak_q <= dstreak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync memory between core fetch, core data and host ports.
// Latency: grants and memory drive are combinational; read data returns one cycle later.
// Backpressure: losers get no grant and core_stall freezes the core; host only served in HALT.
module mem_port_arbiter
    import risc16_bus_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_t state_q;
    arb_state_t state_d;
    owner_t     owner_q;
    owner_t     owner_d;

    logic              gnt_i;
    logic              gnt_d;
    logic              gnt_h;
    logic              sel_en;
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_wdata;
    logic [1:0]        mux_we;
    logic              mux_oe;

    // The core may only be granted while running and no halt is being requested.
    assign sel_en = ~rst & (state_q == ST_RUN) & ~bus.h_halt_req;

    arb_fair_sel #(
        .MAX_DSTREAK (MAX_DSTREAK)
    ) u_fair_sel (
        .clk      (clk),
        .rst      (rst),
        .i_req_i  (bus.i_req),
        .d_req_i  (bus.d_req),
        .enable_i (sel_en),
        .sel_i_o  (gnt_i),
        .sel_d_o  (gnt_d)
    );

    assign gnt_h = ~rst & (state_q == ST_HALT) & bus.h_req;

    // Run/drain/halt sequencing; DRAIN is a single cycle that lets an in-flight read land.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.h_halt_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = bus.h_halt_req ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                if (!bus.h_halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Memory port mux of the single granted requester, and owner of any read issued now.
    always_comb begin
        mux_addr  = '0;
        mux_wdata = '0;
        mux_we    = WE_NONE;
        mux_oe    = 1'b0;
        owner_d   = OWN_NONE;
        if (gnt_i) begin
            mux_addr = bus.i_addr;
            mux_oe   = 1'b1;
            owner_d  = OWN_I;
        end else if (gnt_d) begin
            mux_addr  = bus.d_addr;
            mux_wdata = bus.d_wdata;
            mux_we    = bus.d_we;
            mux_oe    = is_read(bus.d_we);
            owner_d   = is_read(bus.d_we) ? OWN_D : OWN_NONE;
        end else if (gnt_h) begin
            mux_addr  = bus.h_addr;
            mux_wdata = bus.h_wdata;
            mux_we    = bus.h_we;
            mux_oe    = is_read(bus.h_we);
            owner_d   = is_read(bus.h_we) ? OWN_H : OWN_NONE;
        end
    end

    // State and read-owner registers; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign bus.i_gnt = gnt_i;
    assign bus.d_gnt = gnt_d;
    assign bus.h_gnt = gnt_h;

    assign bus.m_addr  = mux_addr;
    assign bus.m_wdata = mux_wdata;
    assign bus.m_we    = mux_we;
    assign bus.m_oe    = mux_oe;

    // Returning data is steered by the owner captured at grant time.
    assign bus.i_rvalid = ~rst & (owner_q == OWN_I);
    assign bus.d_rvalid = ~rst & (owner_q == OWN_D);
    assign bus.h_rvalid = ~rst & (owner_q == OWN_H);

    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;
    assign bus.h_rdata = bus.m_rdata;

    assign bus.h_halted = ~rst & (state_q == ST_HALT);

    assign bus.core_stall = ~rst & ((state_q != ST_RUN)
                                    | (bus.i_req & ~gnt_i)
                                    | (bus.d_req & ~gnt_d));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a cycle-level reference model.
module tb_mem_port_arbiter;

    localparam int MAXD   = 4;
    localparam int M_RUN  = 0;
    localparam int M_DRN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus();

    mem_port_arbiter #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .MAX_DSTREAK (MAXD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word-addressed memory behind the port; read data appears the cycle after m_oe.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (rst) begin
            bus.m_rdata <= 16'h0;
        end else begin
            if (bus.m_oe) bus.m_rdata <= mem[bus.m_addr[8:1]];
            if (bus.m_we[0]) mem[bus.m_addr[8:1]][7:0]  <= bus.m_wdata[7:0];
            if (bus.m_we[1]) mem[bus.m_addr[8:1]][15:8] <= bus.m_wdata[15:8];
        end
    end

    // Reference model state: mode, data grants overtaking a fetch, port expecting data next cycle.
    int  ms     = M_RUN;
    int  streak = 0;
    int  pend   = 0;
    bit  log_en = 1'b0;
    byte glog[$];

    always @(negedge clk) begin : cmp
        logic        ei, ed, eh, eoe;
        logic [15:0] ea, ewd;
        logic [1:0]  ewe;
        int          np;
        ei = 0; ed = 0; eh = 0; eoe = 0; ea = 0; ewd = 0; ewe = 0; np = 0;
        if (!rst) begin
            if (ms == M_RUN && !bus.h_halt_req) begin
                if (bus.d_req && !(bus.i_req && streak == MAXD)) ed = 1;
                else if (bus.i_req) ei = 1;
            end else if (ms == M_HALT) begin
                eh = bus.h_req;
            end
        end
        if (ei) begin
            ea = bus.i_addr; eoe = 1; np = 1;
        end else if (ed) begin
            ea = bus.d_addr; ewe = bus.d_we; ewd = bus.d_wdata;
            eoe = (bus.d_we == 2'b00); np = eoe ? 2 : 0;
        end else if (eh) begin
            ea = bus.h_addr; ewe = bus.h_we; ewd = bus.h_wdata;
            eoe = (bus.h_we == 2'b00); np = eoe ? 3 : 0;
        end

        check("m.i_gnt", bus.i_gnt, ei);
        check("m.d_gnt", bus.d_gnt, ed);
        check("m.h_gnt", bus.h_gnt, eh);
        check("m.i_rvalid", bus.i_rvalid, !rst && pend == 1);
        check("m.d_rvalid", bus.d_rvalid, !rst && pend == 2);
        check("m.h_rvalid", bus.h_rvalid, !rst && pend == 3);
        check("m.i_rdata", bus.i_rdata, bus.m_rdata);
        check("m.d_rdata", bus.d_rdata, bus.m_rdata);
        check("m.h_rdata", bus.h_rdata, bus.m_rdata);
        check("m.m_addr", bus.m_addr, ea);
        check("m.m_oe", bus.m_oe, eoe);
        check("m.m_we", bus.m_we, ewe);
        check("m.m_wdata", bus.m_wdata, ewd);
        check("m.core_stall", bus.core_stall,
              !rst && (ms != M_RUN || (bus.i_req && !ei) || (bus.d_req && !ed)));
        check("m.h_halted", bus.h_halted, !rst && ms == M_HALT);

        if (log_en) begin
            if (bus.i_gnt)      glog.push_back("I");
            else if (bus.d_gnt) glog.push_back("D");
            else if (bus.h_gnt) glog.push_back("H");
            else                glog.push_back("-");
        end

        if (rst) begin
            ms = M_RUN; streak = 0; pend = 0;
        end else begin
            case (ms)
                M_RUN:   if (bus.h_halt_req) ms = M_DRN;
                M_DRN:   ms = bus.h_halt_req ? M_HALT : M_RUN;
                default: if (!bus.h_halt_req) ms = M_RUN;
            endcase
            if (!bus.i_req || ei) streak = 0;
            else if (ed && streak < MAXD) streak++;
            pend = np;
        end
    end

    task automatic idle();
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.h_halt_req = 0;
        bus.h_req = 0; bus.h_we = 0; bus.h_addr = 0; bus.h_wdata = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string tag, input string pat);
        check({tag, ".len"}, glog.size(), pat.len());
        for (int k = 0; k < pat.len(); k++) begin
            byte g;
            g = (k < glog.size()) ? glog[k] : "?";
            check($sformatf("%s[%0d]", tag, k), g, pat[k]);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 16'h0;
        mem[1] = 16'hA5A5;

        // Reset with requests pending: everything must be quiet.
        rst = 1; idle(); bus.i_req = 1; bus.d_req = 1;
        @(negedge clk);
        check("rst.i_gnt", bus.i_gnt, 0);
        check("rst.d_gnt", bus.d_gnt, 0);
        check("rst.core_stall", bus.core_stall, 0);
        check("rst.m_oe", bus.m_oe, 0);
        check("rst.h_halted", bus.h_halted, 0);
        tick(); tick();
        rst = 0; idle();
        tick();

        // Fetch only.
        bus.i_req = 1; bus.i_addr = 16'h0002;
        @(negedge clk);
        check("fetch.i_gnt", bus.i_gnt, 1);
        check("fetch.m_oe", bus.m_oe, 1);
        check("fetch.m_addr", bus.m_addr, 16'h0002);
        tick(); idle();
        @(negedge clk);
        check("fetch.i_rvalid", bus.i_rvalid, 1);
        check("fetch.i_rdata", bus.i_rdata, 16'hA5A5);
        check("fetch.d_rvalid", bus.d_rvalid, 0);
        tick();

        // Contention: fetch and data reads held for 10 cycles.
        glog.delete(); log_en = 1;
        for (int k = 0; k < 10; k++) begin
            bus.i_req = 1; bus.i_addr = 16'h0004;
            bus.d_req = 1; bus.d_addr = 16'h0002;
            tick();
        end
        log_en = 0; idle();
        check_log("contend", "DDDDIDDDDI");
        tick();

        // Data write.
        bus.d_req = 1; bus.d_we = 2'b01; bus.d_addr = 16'h0010; bus.d_wdata = 16'h1234;
        @(negedge clk);
        check("wr.d_gnt", bus.d_gnt, 1);
        check("wr.m_we", bus.m_we, 2'b01);
        check("wr.m_oe", bus.m_oe, 0);
        check("wr.m_wdata", bus.m_wdata, 16'h1234);
        tick(); idle();
        @(negedge clk);
        check("wr.d_rvalid", bus.d_rvalid, 0);
        tick();

        // Halt after a data read grant; core keeps requesting.
        bus.d_req = 1; bus.d_addr = 16'h0002; bus.i_req = 1; bus.i_addr = 16'h0004;
        tick();
        bus.h_halt_req = 1;
        @(negedge clk);
        check("halt.d_gnt", bus.d_gnt, 0);
        check("halt.i_gnt", bus.i_gnt, 0);
        check("halt.d_rvalid", bus.d_rvalid, 1);
        check("halt.d_rdata", bus.d_rdata, 16'hA5A5);
        check("halt.stall", bus.core_stall, 1);
        tick();
        @(negedge clk);
        check("drain.h_halted", bus.h_halted, 0);
        check("drain.stall", bus.core_stall, 1);
        tick();
        bus.h_req = 1; bus.h_we = 2'b11; bus.h_addr = 16'h0020; bus.h_wdata = 16'hBEEF;
        @(negedge clk);
        check("hwr.h_halted", bus.h_halted, 1);
        check("hwr.h_gnt", bus.h_gnt, 1);
        check("hwr.m_we", bus.m_we, 2'b11);
        check("hwr.i_gnt", bus.i_gnt, 0);
        tick();
        bus.h_we = 2'b00;
        @(negedge clk);
        check("hrd.m_oe", bus.m_oe, 1);
        tick();
        bus.h_req = 0;
        @(negedge clk);
        check("hrd.h_rvalid", bus.h_rvalid, 1);
        check("hrd.h_rdata", bus.h_rdata, 16'hBEEF);
        check("hrd.stall", bus.core_stall, 1);
        tick();

        // Resume overlap: host read in the last HALT cycle, fetch granted on resume.
        bus.d_req = 0; bus.h_halt_req = 0;
        bus.h_req = 1; bus.h_we = 2'b00; bus.h_addr = 16'h0020;
        @(negedge clk);
        check("resume.h_gnt", bus.h_gnt, 1);
        tick();
        bus.h_req = 0;
        @(negedge clk);
        check("resume.h_rvalid", bus.h_rvalid, 1);
        check("resume.h_rdata", bus.h_rdata, 16'hBEEF);
        check("resume.i_gnt", bus.i_gnt, 1);
        check("resume.i_rvalid", bus.i_rvalid, 0);
        check("resume.h_halted", bus.h_halted, 0);
        tick(); idle(); tick();

        // Reset in the cycle after a granted fetch.
        bus.i_req = 1; bus.i_addr = 16'h0002;
        tick();
        rst = 1; bus.d_req = 1;
        @(negedge clk);
        check("rstrd.i_rvalid", bus.i_rvalid, 0);
        check("rstrd.stall", bus.core_stall, 0);
        tick();
        rst = 0;
        glog.delete(); log_en = 1;
        for (int k = 0; k < 5; k++) tick();
        log_en = 0; idle();
        check_log("postrst", "DDDDI");
        tick();

        // Halt request withdrawn during DRAIN: back to RUN, never halted.
        bus.h_halt_req = 1;
        tick();
        bus.h_halt_req = 0; bus.i_req = 1;
        @(negedge clk);
        check("drop.h_halted", bus.h_halted, 0);
        check("drop.i_gnt", bus.i_gnt, 0);
        tick();
        @(negedge clk);
        check("drop.h_halted2", bus.h_halted, 0);
        check("drop.i_gnt2", bus.i_gnt, 1);
        tick(); idle(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
